// File: rtl/rhythm_tick_scheduler.sv
`timescale 1ns/1ps
// rhythm_tick_scheduler: single-cycle fall/beat tick enables for the rhythm game, with run/pause/stop
//   sequencing and difficulty changes applied only at beat boundaries (or right away when not running).
// Latency: first fall_tick arrives div cycles after RUN is entered; commands take effect on the next cycle.
// Ports: clk_50m/rst_n; start/pause/resume/stop/diff_req pulses + diff_val in;
//   diff_ack, active_diff, fall_tick, beat_tick, beat_cnt, state out (all registered).
module rhythm_tick_scheduler #(
  parameter int unsigned BASE_DIV       = 5_000_000,
  parameter int unsigned TICKS_PER_BEAT = 8,
  parameter int unsigned CNT_W          = 23
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        resume,
  input  logic        stop,
  input  logic        diff_req,
  input  logic [2:0]  diff_val,
  output logic        diff_ack,
  output logic [2:0]  active_diff,
  output logic        fall_tick,
  output logic        beat_tick,
  output logic [15:0] beat_cnt,
  output logic [1:0]  state
);

  localparam int unsigned SUB_W = $clog2(TICKS_PER_BEAT);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_BEAT - 1);
  localparam logic [CNT_W-1:0] DIV0     = CNT_W'(BASE_DIV);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [SUB_W-1:0] r_sub_cnt;
  logic [15:0]      r_beat_cnt;
  logic [2:0]       r_active_diff;
  logic [2:0]       r_pend;
  logic             r_pend_vld;
  logic             r_fall_tick;
  logic             r_beat_tick;
  logic             r_diff_ack;

  logic [CNT_W-1:0] w_div;
  logic [CNT_W-1:0] w_div_m1;
  logic             w_run_adv;
  logic             w_wrap;
  logic             w_beat;
  logic             w_apply;

  // Difficulty 4..7 is out of the defined range and falls back to the difficulty-1 rate.
  always_comb begin
    w_div = DIV0 >> 1;
    case (r_active_diff)
      3'd0:    w_div = DIV0;
      3'd1:    w_div = DIV0 >> 1;
      3'd2:    w_div = DIV0 >> 2;
      3'd3:    w_div = DIV0 >> 3;
      default: w_div = DIV0 >> 1;
    endcase
  end

  assign w_div_m1 = w_div - CNT_W'(1);

  // Counting only advances in RUN when neither stop nor pause wins this cycle.
  assign w_run_adv = (r_state == S_RUN) && !stop && !pause;
  // '>=' rather than '==' so a count left beyond a freshly shortened period still wraps.
  assign w_wrap    = w_run_adv && (r_tick_cnt >= w_div_m1);
  assign w_beat    = w_wrap && (r_sub_cnt == SUB_LAST);
  // Outside RUN a pending difficulty lands immediately; in RUN only on a beat.
  assign w_apply   = r_pend_vld &&
                     ((r_state == S_IDLE) || (r_state == S_PAUSED) || w_beat);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_tick_cnt    <= '0;
      r_sub_cnt     <= '0;
      r_beat_cnt    <= '0;
      r_active_diff <= 3'd1;
      r_pend        <= '0;
      r_pend_vld    <= 1'b0;
      r_fall_tick   <= 1'b0;
      r_beat_tick   <= 1'b0;
      r_diff_ack    <= 1'b0;
    end else begin
      r_fall_tick <= 1'b0;
      r_beat_tick <= 1'b0;
      r_diff_ack  <= 1'b0;

      if (w_apply) begin
        r_active_diff <= r_pend;
        r_diff_ack    <= 1'b1;
        r_pend_vld    <= 1'b0;
      end
      // A request in the applying cycle overrides the clear above and waits for the next chance.
      if (diff_req) begin
        r_pend     <= diff_val;
        r_pend_vld <= 1'b1;
      end

      if (stop) begin
        r_state    <= S_IDLE;
        r_tick_cnt <= '0;
        r_sub_cnt  <= '0;
        r_beat_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state    <= S_RUN;
              r_tick_cnt <= '0;
              r_sub_cnt  <= '0;
              r_beat_cnt <= '0;
            end
          end
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSED;
            end else if (w_wrap) begin
              r_tick_cnt  <= '0;
              r_fall_tick <= 1'b1;
              r_sub_cnt   <= r_sub_cnt + 1'b1;
              if (w_beat) begin
                r_beat_tick <= 1'b1;
                if (r_beat_cnt != 16'hFFFF) begin
                  r_beat_cnt <= r_beat_cnt + 16'd1;
                end
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
          end
          S_PAUSED: begin
            if (resume) begin
              r_state <= S_RUN;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign diff_ack    = r_diff_ack;
  assign active_diff = r_active_diff;
  assign fall_tick   = r_fall_tick;
  assign beat_tick   = r_beat_tick;
  assign beat_cnt    = r_beat_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_rhythm_tick_scheduler.sv
`timescale 1ns/1ps
// tb_rhythm_tick_scheduler: directed scenarios with hand-computed expectations
//   (BASE_DIV=16, TICKS_PER_BEAT=4, so difficulty 1 -> period 8, difficulty 3 -> period 2).
// Inputs are driven on the falling edge and outputs sampled there too.
module tb_rhythm_tick_scheduler;

  logic        clk_50m = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        pause   = 1'b0;
  logic        resume  = 1'b0;
  logic        stop    = 1'b0;
  logic        diff_req = 1'b0;
  logic [2:0]  diff_val = 3'd0;
  logic        diff_ack;
  logic [2:0]  active_diff;
  logic        fall_tick;
  logic        beat_tick;
  logic [15:0] beat_cnt;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  rhythm_tick_scheduler #(
    .BASE_DIV       (16),
    .TICKS_PER_BEAT (4),
    .CNT_W          (5)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .resume      (resume),
    .stop        (stop),
    .diff_req    (diff_req),
    .diff_val    (diff_val),
    .diff_ack    (diff_ack),
    .active_diff (active_diff),
    .fall_tick   (fall_tick),
    .beat_tick   (beat_tick),
    .beat_cnt    (beat_cnt),
    .state       (state)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    @(negedge clk_50m);
  endtask

  // Steps until fall_tick is seen; n is the number of cycles taken (== max on timeout).
  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!fall_tick && n < max);
  endtask

  task automatic wait_beat(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!beat_tick && n < max);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  32'(state), 0);
    chk({tag, "_diff"},   32'(active_diff), 1);
    chk({tag, "_fall"},   32'(fall_tick), 0);
    chk({tag, "_beat"},   32'(beat_tick), 0);
    chk({tag, "_ack"},    32'(diff_ack), 0);
    chk({tag, "_bcnt"},   32'(beat_cnt), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    int ticks_seen;
    int bad;

    // Reset state
    repeat (2) @(negedge clk_50m);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // 1: difficulty 1 -> period 8, beat every 4th tick
    start = 1'b1; step(); start = 1'b0;
    chk("t1_state_run", 32'(state), 1);
    for (int i = 1; i <= 8; i++) begin
      wait_tick(100, n);
      chk("t1_period", n, 8);
      chk("t1_beat_tick", 32'(beat_tick), (i % 4 == 0) ? 1 : 0);
      chk("t1_beat_cnt", 32'(beat_cnt), i / 4);
    end

    // 3: pause with count frozen at 3, hold 50, resume -> tick 5 cycles later
    wait_tick(100, n);
    chk("t3_pre_period", n, 8);
    repeat (3) step();
    pause = 1'b1; step(); pause = 1'b0;
    chk("t3_state_paused", 32'(state), 2);
    ticks_seen = 0;
    bad = 0;
    repeat (50) begin
      step();
      if (fall_tick || beat_tick) ticks_seen++;
      if (beat_cnt != 16'd2) bad++;
    end
    chk("t3_no_ticks_paused", ticks_seen, 0);
    chk("t3_bcnt_frozen", bad, 0);
    resume = 1'b1; step(); resume = 1'b0;
    chk("t3_state_run", 32'(state), 1);
    wait_tick(100, n);
    chk("t3_resume_delay", n, 5);

    // 2: mid-beat difficulty request waits for the beat boundary
    repeat (3) step();
    diff_req = 1'b1; diff_val = 3'd3; step(); diff_req = 1'b0;
    chk("t2_diff_held", 32'(active_diff), 1);
    acks = 0;
    n = 0;
    do begin
      step();
      n++;
      if (!beat_tick && diff_ack) acks++;
    end while (!beat_tick && n < 100);
    chk("t2_early_ack", acks, 0);
    chk("t2_beat_seen", 32'(beat_tick), 1);
    chk("t2_ack_on_beat", 32'(diff_ack), 1);
    chk("t2_diff_applied", 32'(active_diff), 3);
    chk("t2_beat_cnt", 32'(beat_cnt), 3);
    wait_tick(100, n);
    chk("t2_new_period_a", n, 2);
    chk("t2_ack_cleared", 32'(diff_ack), 0);
    wait_tick(100, n);
    chk("t2_new_period_b", n, 2);

    // 4: stop wins over pause/start; difficulty applied at once in IDLE
    stop = 1'b1; pause = 1'b1; start = 1'b1; step();
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    chk("t4_state_idle", 32'(state), 0);
    chk("t4_bcnt_clear", 32'(beat_cnt), 0);
    ticks_seen = 0;
    repeat (20) begin
      step();
      if (fall_tick || beat_tick || state != 2'd0) ticks_seen++;
    end
    chk("t4_idle_quiet", ticks_seen, 0);
    chk("t4_diff_kept", 32'(active_diff), 3);
    diff_req = 1'b1; diff_val = 3'd0; step(); diff_req = 1'b0;
    chk("t4_ack_not_yet", 32'(diff_ack), 0);
    step();
    chk("t4_ack", 32'(diff_ack), 1);
    chk("t4_diff0", 32'(active_diff), 0);
    step();
    chk("t4_ack_pulse", 32'(diff_ack), 0);

    // 5: beat_cnt saturation
    diff_req = 1'b1; diff_val = 3'd3; step(); diff_req = 1'b0;
    step();
    chk("t5_diff3", 32'(active_diff), 3);
    start = 1'b1; step(); start = 1'b0;
    wait_tick(100, n);
    chk("t5_first_period", n, 2);
    force dut.r_beat_cnt = 16'hFFFE;
    #1;
    release dut.r_beat_cnt;
    wait_beat(100, n);
    chk("t5_beat_a", 32'(beat_tick), 1);
    chk("t5_bcnt_a", 32'(beat_cnt), 32'hFFFF);
    wait_beat(100, n);
    chk("t5_beat_b", 32'(beat_tick), 1);
    chk("t5_beat_spacing", n, 8);
    chk("t5_bcnt_sat", 32'(beat_cnt), 32'hFFFF);

    // 6: reset mid-run, then difficulty 5 -> period 8
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge clk_50m);
    rst_n = 1'b1;
    step();
    chk("t6_idle_after", 32'(state), 0);
    diff_req = 1'b1; diff_val = 3'd5; step(); diff_req = 1'b0;
    step();
    chk("t6_ack", 32'(diff_ack), 1);
    chk("t6_diff5", 32'(active_diff), 5);
    start = 1'b1; step(); start = 1'b0;
    wait_tick(100, n);
    chk("t6_first_period", n, 8);
    wait_tick(100, n);
    chk("t6_period", n, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
